spi_burst_memory: RTL and testbench

Parametrised SPI-slave register memory: an off-chip SPI master reads and writes an internal word array over sclk/cs/mosi/miso. It is the successor to the fixed 8-bit/mode-0 SPI memory, adding configurable address/data width, all four SPI modes, multi-word bursts with address auto-increment, and clean abort on chip-select deassertion. It sits at the FPGA pin boundary, between the raw SPI pins and the debug LEDs.

---
 rtl/spi_mem_pkg.sv | 22 ++
 rtl/spi_pin_sync.sv | 31 +++
 rtl/spi_burst_memory.sv | 148 ++++++++++++++
 tb/tb_spi_burst_memory.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for spi_burst_memory: FSM state encoding (also
// shown on the debug LEDs), the R/W header bit value and SPI mode decoding.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HEADER    = 3'd1,
    RD_LOAD   = 3'd2,
    RD_SHIFT  = 3'd3,
    WR_SHIFT  = 3'd4,
    WR_COMMIT = 3'd5,
    HOLD      = 3'd6
  } state_t;

  localparam logic RW_READ = 1'b1;

  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with registered level
// and single-cycle rise/fall pulses (3 clk pin-to-pulse latency).
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
      level  <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      level  <= sync_q[1];
      rise   <= sync_q[1] & ~level;
      fall   <= ~sync_q[1] & level;
    end
  end

endmodule

// File: rtl/spi_burst_memory.sv
// SPI-slave word memory with selectable mode and width; define SPI_MEM_BURST_EN
// for auto-incrementing multi-word bursts, otherwise one word per frame.
module spi_burst_memory
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic [3:0] leds
);

`ifdef SPI_MEM_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif
  localparam int   DEPTH       = 2 ** ADDR_W;
  localparam int   CNT_MAX     = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam int   CNT_W       = $clog2(CNT_MAX + 1);
  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_pin_sync #(.RST_VAL(1'(CPOL))) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .pin(sclk_pin),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .pin(cs_pin),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin(mosi_pin),
    .level(mosi), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_level, cs_level, mosi_rise, mosi_fall};

  logic sample_edge, shift_edge;
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   shreg, rd_data;
  logic [CNT_W-1:0]    bit_cnt;
  logic                load_phase, miso_q, miso_oe;
  logic                hdr_last, word_last;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign hdr_last  = sample_edge && (bit_cnt == CNT_W'(ADDR_W));
  assign word_last = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (cs_fall) state_next = HEADER;
        HEADER:    if (hdr_last) state_next = (mosi == RW_READ) ? RD_LOAD : WR_SHIFT;
        RD_LOAD:   if (load_phase) state_next = RD_SHIFT;
        RD_SHIFT:  if (word_last) state_next = BURST ? RD_LOAD : HOLD;
        WR_SHIFT:  if (word_last) state_next = WR_COMMIT;
        WR_COMMIT: state_next = BURST ? WR_SHIFT : HOLD;
        HOLD:      state_next = HOLD;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      load_phase <= 1'b0;
      miso_q     <= 1'b0;
    end else if (cs_rise) begin
      bit_cnt    <= '0;
      load_phase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt    <= '0;
          load_phase <= 1'b0;
        end
        HEADER: if (sample_edge) begin
          if (hdr_last) begin
            bit_cnt <= '0;
          end else begin
            addr    <= ADDR_W'({addr, mosi});
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        // Two cycles: the first lets rd_data capture mem[addr], the second loads it.
        RD_LOAD: begin
          load_phase <= ~load_phase;
          if (load_phase) shreg <= rd_data;
        end
        RD_SHIFT: begin
          if (shift_edge) begin
            miso_q <= shreg[DATA_W-1];
            shreg  <= shreg << 1;
          end
          if (sample_edge) begin
            bit_cnt <= word_last ? '0 : bit_cnt + CNT_W'(1);
            if (word_last && BURST) addr <= addr + ADDR_W'(1);
          end
        end
        WR_SHIFT: if (sample_edge) begin
          shreg   <= {shreg[DATA_W-2:0], mosi};
          bit_cnt <= word_last ? '0 : bit_cnt + CNT_W'(1);
        end
        WR_COMMIT: if (BURST) addr <= addr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the word array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    rd_data <= mem[addr];
    if (state == WR_COMMIT) mem[addr] <= shreg;
  end

  assign miso_oe  = (state == RD_LOAD) || (state == RD_SHIFT);
  assign miso_pin = miso_oe ? miso_q : 1'bz;
  assign leds     = {miso_oe, state};

endmodule

// File: tb/tb_spi_burst_memory.sv
// Directed bench: a mode-0 default instance and a mode-3 16-bit instance driven
// by a bit-level SPI master task; checks data, LED state and reset behaviour.
module tb_spi_burst_memory;

  localparam int H = 6;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk0, cs0, mosi0, sclk3, cs3, mosi3;
  wire        miso0, miso3;
  logic [3:0] leds0, leds3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] tx_w [4];
  logic [15:0] rx_w [4];
  logic [3:0]  hdr_leds, data_leds, hold_leds, rst_leds;

  always #5 clk = ~clk;

  spi_burst_memory dut0 (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk0), .cs_pin(cs0),
    .mosi_pin(mosi0), .miso_pin(miso0), .leds(leds0)
  );

  spi_burst_memory #(.ADDR_W(4), .DATA_W(16), .CPOL(1), .CPHA(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk3), .cs_pin(cs3),
    .mosi_pin(mosi3), .miso_pin(miso3), .leds(leds3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sclk(input int d, input logic v);
    if (d == 0) sclk0 = v; else sclk3 = v;
  endtask

  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs0 = v; else cs3 = v;
  endtask

  task automatic set_mosi(input int d, input logic v);
    if (d == 0) mosi0 = v; else mosi3 = v;
  endtask

  function automatic logic [3:0] leds_of(input int d);
    return (d == 0) ? leds0 : leds3;
  endfunction

  // d == 0: mode 0 (CPOL=CPHA=0); otherwise mode 3 (CPOL=CPHA=1).
  task automatic xfer_bit(input int d, input logic b, output logic r);
    logic cp;
    cp = (d != 0);
    if (!cp) begin
      set_mosi(d, b);
      wait_clk(H);
      r = (d == 0) ? miso0 : miso3;
      set_sclk(d, 1'b1);
      wait_clk(H);
      set_sclk(d, 1'b0);
    end else begin
      set_sclk(d, 1'b0);
      set_mosi(d, b);
      wait_clk(H);
      r = (d == 0) ? miso0 : miso3;
      set_sclk(d, 1'b1);
      wait_clk(H);
    end
  endtask

  // One frame: header {addr, rw}, then nwords words from tx_w (read data to rx_w).
  // abort_bits >= 0 stops after that many data bits, optionally pulsing rst_n first.
  task automatic frame(input int d, input int addr, input logic rw, input int nwords,
                       input int abort_bits, input bit use_reset);
    int          aw, dw, nbits;
    logic        r, stop, cp;
    logic [15:0] word, rd;
    cp    = (d != 0);
    aw    = (d == 0) ? 7 : 4;
    dw    = (d == 0) ? 8 : 16;
    nbits = 0;
    stop  = 1'b0;
    set_cs(d, 1'b0);
    wait_clk(H);
    for (int i = aw - 1; i >= 0; i--) begin
      xfer_bit(d, addr[i], r);
      if (i == aw - 3) begin
        wait_clk(5);
        hdr_leds = leds_of(d);
      end
    end
    xfer_bit(d, rw, r);
    for (int w = 0; w < nwords && !stop; w++) begin
      word = tx_w[w];
      rd   = '0;
      for (int b = dw - 1; b >= 0 && !stop; b--) begin
        if (abort_bits >= 0 && nbits == abort_bits) begin
          stop = 1'b1;
        end else begin
          xfer_bit(d, word[b], r);
          rd[b] = r;
          nbits++;
          if (b == dw - 1) begin
            wait_clk(5);
            if (w == 0) data_leds = leds_of(d);
            if (w == 1) hold_leds = leds_of(d);
          end
        end
      end
      rx_w[w] = rd;
    end
    if (stop && use_reset) begin
      rst_n = 1'b0;
      #1 rst_leds = leds_of(d);
      wait_clk(3);
      rst_n = 1'b1;
    end
    wait_clk(H);
    set_sclk(d, cp);
    set_cs(d, 1'b1);
    set_mosi(d, 1'b0);
    wait_clk(12);
  endtask

  task automatic wr1(input int d, input int addr, input logic [15:0] v);
    tx_w[0] = v;
    frame(d, addr, 1'b0, 1, -1, 1'b0);
  endtask

  task automatic rd1(input int d, input int addr);
    tx_w[0] = '0;
    frame(d, addr, 1'b1, 1, -1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
    sclk3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0;
    wait_clk(4);
    check("reset_leds0", 32'(leds0), 32'h0);
    check("reset_leds3", 32'(leds3), 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // Basic mode-0 write then read.
    wr1(0, 'h12, 16'h00A5);
    rd1(0, 'h12);
    check("rd_0x12", 32'(rx_w[0][7:0]), 32'hA5);
    check("hdr_leds_no_drive", 32'(hdr_leds), 32'h1);
    check("data_leds_drive", 32'(data_leds), 32'hB);
    check("idle_leds_after_read", 32'(leds0), 32'h0);

    // Aborted write leaves the old word intact.
    wr1(0, 'h05, 16'h005A);
    tx_w[0] = 16'h00FF;
    frame(0, 'h05, 1'b0, 1, 4, 1'b0);
    check("abort_leds_idle", 32'(leds0), 32'h0);
    rd1(0, 'h05);
    check("rd_after_abort", 32'(rx_w[0][7:0]), 32'h5A);

`ifdef SPI_MEM_BURST_EN
    tx_w[0] = 16'h0011; tx_w[1] = 16'h0022; tx_w[2] = 16'h0033;
    frame(0, 'h7E, 1'b0, 3, -1, 1'b0);
    tx_w[0] = '0; tx_w[1] = '0; tx_w[2] = '0;
    frame(0, 'h7E, 1'b1, 3, -1, 1'b0);
    check("burst_rd0", 32'(rx_w[0][7:0]), 32'h11);
    check("burst_rd1", 32'(rx_w[1][7:0]), 32'h22);
    check("burst_rd2", 32'(rx_w[2][7:0]), 32'h33);
    rd1(0, 'h00);
    check("wrap_0x00", 32'(rx_w[0][7:0]), 32'h33);
`else
    wr1(0, 'h11, 16'h00C3);
    tx_w[0] = 16'h0001; tx_w[1] = 16'h0002;
    frame(0, 'h10, 1'b0, 2, -1, 1'b0);
    check("single_hold_leds", 32'(hold_leds), 32'h6);
    rd1(0, 'h10);
    check("single_rd_0x10", 32'(rx_w[0][7:0]), 32'h01);
    rd1(0, 'h11);
    check("single_rd_0x11", 32'(rx_w[0][7:0]), 32'hC3);
`endif

    // Reset in the middle of a read data phase.
    wr1(0, 'h40, 16'h003C);
    tx_w[0] = '0;
    frame(0, 'h40, 1'b1, 1, 3, 1'b1);
    check("pre_reset_data_leds", 32'(data_leds), 32'hB);
    check("reset_midframe_leds", 32'(rst_leds), 32'h0);
    check("after_reset_idle", 32'(leds0), 32'h0);
    rd1(0, 'h40);
    check("rd_0x40_after_reset", 32'(rx_w[0][7:0]), 32'h3C);
    rd1(0, 'h12);
    check("rd_0x12_after_reset", 32'(rx_w[0][7:0]), 32'hA5);

    // Mode 3, 16-bit words, 4-bit address.
    wr1(1, 'h3, 16'hBEEF);
    wr1(1, 'hF, 16'h1234);
    rd1(1, 'h3);
    check("m3_rd_0x3", 32'(rx_w[0]), 32'hBEEF);
    check("m3_data_leds", 32'(data_leds), 32'hB);
    rd1(1, 'hF);
    check("m3_rd_0xF", 32'(rx_w[0]), 32'h1234);
    check("m3_idle_leds", 32'(leds3), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
